ps2_key_fifo: RTL and testbench

- Stage directly downstream of the PS/2 interface. Consumes its byte stream (`key_data[7:0]` plus a one-cycle `key_pressed` strobe).
- Decodes PS/2 Set-2 prefixes (E0 extended, F0 break) and tracks the shift keys.
- Translates make codes to ASCII and buffers characters in a first-word-fall-through FIFO, so the processor reads keystrokes at its own pace without losing them.

---
 rtl/ps2_key_fifo_if.sv | 26 ++
 rtl/ps2_key_fifo.sv | 159 +++++++++++++++
 tb/tb_ps2_key_fifo.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_fifo_if.sv
// ps2_key_fifo_if: scan-code input, FIFO read side and status of ps2_key_fifo.
// master = producer/consumer side (PS/2 front end + processor), slave = the FIFO.
interface ps2_key_fifo_if #(
   parameter int unsigned ADDR_W = 4
);
   logic [7:0]      key_data;
   logic            key_pressed;
   logic            rd_en;
   logic            clr_ovf;
   logic [8:0]      rd_data;
   logic            empty;
   logic            full;
   logic [ADDR_W:0] count;
   logic            overflow;
   logic            shift_held;

   modport master (
      output key_data, key_pressed, rd_en, clr_ovf,
      input  rd_data, empty, full, count, overflow, shift_held
   );

   modport slave (
      input  key_data, key_pressed, rd_en, clr_ovf,
      output rd_data, empty, full, count, overflow, shift_held
   );
endinterface

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: PS/2 Set-2 prefix decoder, shift tracker, scan-code to ASCII
// translator and first-word-fall-through character FIFO.
// Optional: define PS2_KEY_FIFO_BREAK_EVENTS_EN to also push mapped break
// events with rd_data[8]=1; otherwise rd_data[8] is always 0.
module ps2_key_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input logic           inclock,
   input logic           resetn,
   ps2_key_fifo_if.slave bus
);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned DATA_W = 9;

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   state_t              state, state_nxt;
   logic                ev_c, ev_ext_c, ev_brk_c;
   logic                shift_l, shift_r;
   logic                map_hit_c, push_c, pop_c, push_eff_c, drop_c;
   logic [7:0]          base_ascii_c, ascii_c;
   logic [DATA_W-1:0]   wr_data_c;
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count_q;
   logic                ovf_q;
   logic                empty_c, full_c;
   logic [DATA_W-1:0]   mem [DEPTH];

   // Prefix FSM state register; a reset mid-prefix discards the partial prefix.
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Prefix FSM next state and event classification; only strobe cycles advance it.
   always_comb begin
      state_nxt = state;
      ev_c      = 1'b0;
      ev_ext_c  = 1'b0;
      ev_brk_c  = 1'b0;
      if (bus.key_pressed) begin
         case (state)
            S_IDLE: begin
               if (bus.key_data == 8'hE0)      state_nxt = S_EXT;
               else if (bus.key_data == 8'hF0) state_nxt = S_BRK;
               else                            ev_c      = 1'b1;
            end
            S_EXT: begin
               if (bus.key_data == 8'hF0) state_nxt = S_EXT_BRK;
               else begin
                  ev_c      = 1'b1;
                  ev_ext_c  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_BRK: begin
               ev_c      = 1'b1;
               ev_brk_c  = 1'b1;
               state_nxt = S_IDLE;
            end
            S_EXT_BRK: begin
               ev_c      = 1'b1;
               ev_ext_c  = 1'b1;
               ev_brk_c  = 1'b1;
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Scan code to lowercase/unshifted ASCII lookup.
   always_comb begin
      map_hit_c    = 1'b1;
      base_ascii_c = 8'h00;
      case (bus.key_data)
         8'h1C: base_ascii_c = 8'h61;  8'h32: base_ascii_c = 8'h62;
         8'h21: base_ascii_c = 8'h63;  8'h23: base_ascii_c = 8'h64;
         8'h24: base_ascii_c = 8'h65;  8'h2B: base_ascii_c = 8'h66;
         8'h34: base_ascii_c = 8'h67;  8'h33: base_ascii_c = 8'h68;
         8'h43: base_ascii_c = 8'h69;  8'h3B: base_ascii_c = 8'h6A;
         8'h42: base_ascii_c = 8'h6B;  8'h4B: base_ascii_c = 8'h6C;
         8'h3A: base_ascii_c = 8'h6D;  8'h31: base_ascii_c = 8'h6E;
         8'h44: base_ascii_c = 8'h6F;  8'h4D: base_ascii_c = 8'h70;
         8'h15: base_ascii_c = 8'h71;  8'h2D: base_ascii_c = 8'h72;
         8'h1B: base_ascii_c = 8'h73;  8'h2C: base_ascii_c = 8'h74;
         8'h3C: base_ascii_c = 8'h75;  8'h2A: base_ascii_c = 8'h76;
         8'h1D: base_ascii_c = 8'h77;  8'h22: base_ascii_c = 8'h78;
         8'h35: base_ascii_c = 8'h79;  8'h1A: base_ascii_c = 8'h7A;
         8'h45: base_ascii_c = 8'h30;  8'h16: base_ascii_c = 8'h31;
         8'h1E: base_ascii_c = 8'h32;  8'h26: base_ascii_c = 8'h33;
         8'h25: base_ascii_c = 8'h34;  8'h2E: base_ascii_c = 8'h35;
         8'h36: base_ascii_c = 8'h36;  8'h3D: base_ascii_c = 8'h37;
         8'h3E: base_ascii_c = 8'h38;  8'h46: base_ascii_c = 8'h39;
         8'h29: base_ascii_c = 8'h20;  8'h5A: base_ascii_c = 8'h0D;
         8'h66: base_ascii_c = 8'h08;
         default: map_hit_c = 1'b0;
      endcase
   end

   // Shift applies to letters only and uses the shift state before this byte.
   always_comb begin
      ascii_c = base_ascii_c;
      if (bus.shift_held && (base_ascii_c >= 8'h61)) ascii_c = base_ascii_c - 8'h20;
`ifdef PS2_KEY_FIFO_BREAK_EVENTS_EN
      push_c    = ev_c && !ev_ext_c && map_hit_c;
      wr_data_c = {ev_brk_c, ascii_c};
`else
      push_c    = ev_c && !ev_ext_c && !ev_brk_c && map_hit_c;
      wr_data_c = {1'b0, ascii_c};
`endif
      pop_c      = bus.rd_en && !empty_c;
      push_eff_c = push_c && (!full_c || pop_c);
      drop_c     = push_c && full_c && !pop_c;
   end

   // Left/right shift tracking from non-extended make/break events.
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         shift_l <= 1'b0;
         shift_r <= 1'b0;
      end else if (ev_c && !ev_ext_c) begin
         if (bus.key_data == 8'h12) shift_l <= !ev_brk_c;
         if (bus.key_data == 8'h59) shift_r <= !ev_brk_c;
      end
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge inclock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push_eff_c) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop_c)      rd_ptr <= rd_ptr + ADDR_W'(1);
         if (push_eff_c && !pop_c)      count_q <= count_q + CNT_W'(1);
         else if (pop_c && !push_eff_c) count_q <= count_q - CNT_W'(1);
         if (drop_c)           ovf_q <= 1'b1;
         else if (bus.clr_ovf) ovf_q <= 1'b0;
      end
   end

   // Character storage; contents need no reset since empty masks the head.
   always_ff @(posedge inclock) begin
      if (push_eff_c) mem[wr_ptr] <= wr_data_c;
   end

   assign empty_c        = (count_q == '0);
   assign full_c         = (count_q == CNT_W'(DEPTH));
   assign bus.empty      = empty_c;
   assign bus.full       = full_c;
   assign bus.count      = count_q;
   assign bus.overflow   = ovf_q;
   assign bus.shift_held = shift_l | shift_r;
   assign bus.rd_data    = empty_c ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo: directed table-driven bench for ps2_key_fifo plus
// hand-written sequences for fill/overflow, reset mid-prefix and break events.
module tb_ps2_key_fifo;
   logic inclock = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad   = 0;

   always #5 inclock = ~inclock;

   ps2_key_fifo_if #(.ADDR_W(4)) bus ();

   ps2_key_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .inclock (inclock),
      .resetn  (resetn),
      .bus     (bus)
   );

   typedef struct {
      logic       kp;
      logic [7:0] code;
      logic       rd;
      logic       clr;
      logic [4:0] cnt;
      logic       ovf;
      logic       sh;
      logic [8:0] data;
   } vec_t;

   vec_t       vq[$];
   logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                           8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                           8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                           8'h35, 8'h1A};

   function automatic vec_t mk(input logic kp, input logic [7:0] code, input logic rd,
                               input logic clr, input logic [4:0] cnt, input logic ovf,
                               input logic sh, input logic [8:0] data);
      vec_t v;
      v.kp = kp; v.code = code; v.rd = rd; v.clr = clr;
      v.cnt = cnt; v.ovf = ovf; v.sh = sh; v.data = data;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [4:0] cnt, input logic ovf,
                            input logic sh, input logic [8:0] data);
      chk({tag, ".count"},    16'(bus.count),      16'(cnt));
      chk({tag, ".empty"},    16'(bus.empty),      16'(cnt == 5'd0));
      chk({tag, ".full"},     16'(bus.full),       16'(cnt == 5'd16));
      chk({tag, ".overflow"}, 16'(bus.overflow),   16'(ovf));
      chk({tag, ".shift"},    16'(bus.shift_held), 16'(sh));
      chk({tag, ".rd_data"},  16'(bus.rd_data),    16'(data));
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic step(input logic kp, input logic [7:0] code, input logic rd, input logic clr);
      bus.key_pressed = kp;
      bus.key_data    = code;
      bus.rd_en       = rd;
      bus.clr_ovf     = clr;
      @(posedge inclock);
      #1;
      bus.key_pressed = 1'b0;
      bus.key_data    = 8'h00;
      bus.rd_en       = 1'b0;
      bus.clr_ovf     = 1'b0;
   endtask

   initial begin
      bus.key_pressed = 1'b0;
      bus.key_data    = 8'h00;
      bus.rd_en       = 1'b0;
      bus.clr_ovf     = 1'b0;
      resetn          = 1'b0;

      // kp, code, rd, clr -> count, overflow, shift_held, rd_data
      vq.push_back(mk(1, 8'h1C, 0, 0, 1, 0, 0, 9'h061));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h12, 0, 0, 0, 0, 1, 9'h000));
      vq.push_back(mk(1, 8'h1C, 0, 0, 1, 0, 1, 9'h041));
      vq.push_back(mk(1, 8'h16, 0, 0, 2, 0, 1, 9'h041));
      vq.push_back(mk(1, 8'hF0, 0, 0, 2, 0, 1, 9'h041));
      vq.push_back(mk(1, 8'h12, 0, 0, 2, 0, 0, 9'h041));
      vq.push_back(mk(1, 8'h1C, 0, 0, 3, 0, 0, 9'h041));
      vq.push_back(mk(0, 8'h00, 1, 0, 2, 0, 0, 9'h031));
      vq.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 9'h061));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h59, 0, 0, 0, 0, 1, 9'h000));
      vq.push_back(mk(1, 8'h1A, 0, 0, 1, 0, 1, 9'h05A));
      vq.push_back(mk(1, 8'hF0, 0, 0, 1, 0, 1, 9'h05A));
      vq.push_back(mk(1, 8'h59, 0, 0, 1, 0, 0, 9'h05A));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h75, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h75, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h29, 0, 0, 1, 0, 0, 9'h020));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h45, 0, 0, 1, 0, 0, 9'h030));
      vq.push_back(mk(1, 8'h66, 0, 0, 2, 0, 0, 9'h030));
      vq.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 9'h008));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h76, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h29, 1, 0, 1, 0, 0, 9'h020));
      vq.push_back(mk(1, 8'h1A, 1, 0, 1, 0, 0, 9'h07A));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h1C, 0, 0, 1, 0, 0, 9'h061));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h12, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hF0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h12, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h1C, 0, 0, 1, 0, 0, 9'h061));
      vq.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 0, 9'h000));
      vq.push_back(mk(1, 8'h5A, 0, 0, 0, 0, 0, 9'h000));

      #12;
      check_all("reset", 5'd0, 1'b0, 1'b0, 9'h000);
      @(negedge inclock);
      resetn = 1'b1;
      @(posedge inclock);
      #1;

      foreach (vq[i]) begin
         step(vq[i].kp, vq[i].code, vq[i].rd, vq[i].clr);
         check_all($sformatf("v%0d", i), vq[i].cnt, vq[i].ovf, vq[i].sh, vq[i].data);
      end

      // Fill to DEPTH, overflow on the 17th, clear, then push+pop while full.
      for (int i = 0; i < 16; i++) step(1'b1, lc[i], 1'b0, 1'b0);
      check_all("fill16", 5'd16, 1'b0, 1'b0, 9'h061);
      step(1'b1, lc[16], 1'b0, 1'b0);
      check_all("drop17", 5'd16, 1'b1, 1'b0, 9'h061);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_all("clr_ovf", 5'd16, 1'b0, 1'b0, 9'h061);
      step(1'b1, 8'h29, 1'b1, 1'b0);
      check_all("full_push_pop", 5'd16, 1'b0, 1'b0, 9'h062);
      step(1'b1, 8'h29, 1'b0, 1'b1);
      check_all("drop_with_clr", 5'd16, 1'b1, 1'b0, 9'h062);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_all("clr_ovf2", 5'd16, 1'b0, 1'b0, 9'h062);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("drain%0d", i), 16'(bus.rd_data), 16'(9'h061 + 9'(i)));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_space", 16'(bus.rd_data), 16'h0020);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_all("drained", 5'd0, 1'b0, 1'b0, 9'h000);

      // Reset after a break prefix: the prefix must be forgotten.
      step(1'b1, 8'h29, 1'b0, 1'b0);
      step(1'b1, 8'hF0, 1'b0, 1'b0);
      resetn = 1'b0;
      #2;
      check_all("mid_reset", 5'd0, 1'b0, 1'b0, 9'h000);
      @(posedge inclock);
      #1;
      resetn = 1'b1;
      step(1'b1, 8'h45, 1'b0, 1'b0);
      check_all("after_reset", 5'd1, 1'b0, 1'b0, 9'h030);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Break events on a mapped key.
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      check_all("enter_make", 5'd1, 1'b0, 1'b0, 9'h00D);
      step(1'b1, 8'hF0, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef PS2_KEY_FIFO_BREAK_EVENTS_EN
      check_all("enter_brk", 5'd2, 1'b0, 1'b0, 9'h00D);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_all("enter_brk_head", 5'd1, 1'b0, 1'b0, 9'h10D);
      step(1'b0, 8'h00, 1'b1, 1'b0);
`else
      check_all("enter_brk", 5'd1, 1'b0, 1'b0, 9'h00D);
      step(1'b0, 8'h00, 1'b1, 1'b0);
`endif
      check_all("final", 5'd0, 1'b0, 1'b0, 9'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
